// File: rtl/vram_pkg.sv
// Shared definitions for the display video RAM controller.
// State encoding, legal read latencies and a constant log2 helper.
package vram_pkg;

    localparam logic [0:0] VRAM_IDLE = 1'b0;
    localparam logic [0:0] VRAM_FILL = 1'b1;

    localparam int RLAT_REG  = 1;
    localparam int RLAT_PIPE = 2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_core.sv
// Simple dual-port word array with a registered read port.
// No reset so that synthesis maps it straight onto block RAM.
module vram_core
    import vram_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read samples the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_ctrl.sv
// Video RAM controller: dual-port array, fill engine, read
// latency selection, read-during-write bypass and range masking.
module vram_ctrl
    import vram_pkg::*;
#(
    parameter int                DATA_W         = 6,
    parameter int                ADDR_W         = 11,
    parameter int                DEPTH          = 2048,
    parameter int                READ_LAT       = 1,
    parameter bit                RDW_NEW        = 1'b0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] RESET_FILL     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] din,
    output logic              w_ready,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    if (READ_LAT != RLAT_REG && READ_LAT != RLAT_PIPE) begin : g_bad_lat
        $error("vram_ctrl: READ_LAT must be 1 or 2");
    end
    if (clog2(DEPTH) > ADDR_W) begin : g_bad_depth
        $error("vram_ctrl: DEPTH exceeds address space");
    end

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [DATA_W-1:0] r_fill_val;

    logic              w_fill;
    logic              w_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rd_oor;
    logic              w_wr_oor;
    logic              w_byp;
    logic              w_re;
    logic [DATA_W-1:0] w_core_q;
    logic [DATA_W-1:0] w_s1_data;

    assign w_fill = (r_state == VRAM_FILL);
    assign w_last = (r_fill_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= CLEAR_ON_RESET ? VRAM_FILL : VRAM_IDLE;
            r_fill_cnt <= '0;
            r_fill_val <= RESET_FILL;
        end else begin
            unique case (r_state)
                VRAM_IDLE: begin
                    if (fill_start) begin
                        r_state    <= VRAM_FILL;
                        r_fill_cnt <= '0;
                        r_fill_val <= fill_value;
                    end
                end
                VRAM_FILL: begin
                    if (w_last) begin
                        r_state <= VRAM_IDLE;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                    end
                end
                default: r_state <= VRAM_IDLE;
            endcase
        end
    end

    assign w_ready   = ~w_fill;
    assign fill_busy = w_fill;
    assign fill_done = w_fill & w_last;

    // The fill engine owns the write port; nothing is written while in reset.
    assign w_wr_oor = ({1'b0, write_addr} >= DEPTH_W);
    assign w_rd_oor = ({1'b0, read_addr} >= DEPTH_W);
    assign w_we     = ~reset & (w_fill | (w_en & ~w_wr_oor));
    assign w_waddr  = w_fill ? r_fill_cnt : write_addr;
    assign w_wdata  = w_fill ? r_fill_val : din;
    assign w_byp    = RDW_NEW & w_we & (w_waddr == read_addr);
    assign w_re     = r_en & ~reset;

    vram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (read_addr),
        .o_rdata (w_core_q)
    );

    logic              r_v1;
    logic              r_zero1;
    logic              r_byp1;
    logic [DATA_W-1:0] r_bypd1;

    // r_zero1 starts set so dout reads zero until the first read lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1    <= 1'b0;
            r_zero1 <= 1'b1;
            r_byp1  <= 1'b0;
            r_bypd1 <= '0;
        end else begin
            r_v1 <= r_en;
            if (r_en) begin
                r_zero1 <= w_rd_oor;
                r_byp1  <= w_byp;
                r_bypd1 <= w_wdata;
            end
        end
    end

    assign w_s1_data = r_zero1 ? '0 : (r_byp1 ? r_bypd1 : w_core_q);

    if (READ_LAT == RLAT_PIPE) begin : g_pipe
        logic              r_v2;
        logic [DATA_W-1:0] r_dout;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v2   <= 1'b0;
                r_dout <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_dout <= w_s1_data;
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_v2;
    end else begin : g_reg
        assign dout       = w_s1_data;
        assign dout_valid = r_v1;
    end

endmodule
